// File: rtl/alu_pkg.sv
// Shared constants and flag type for the registered add/subtract unit.
package alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int ALU_WIDTH = 7;

  typedef struct packed {
    logic cf;
    logic sf;
    logic zf;
    logic of;
  } alu_flags_t;

  // Flag state that matches a zero result.
  localparam alu_flags_t ALU_FLAGS_RST = '{cf: 1'b0, sf: 1'b0, zf: 1'b1, of: 1'b0};

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor producing raw result, carry/borrow and signed overflow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cf_o,
  output logic             of_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Subtract is A + ~B + 1; the +1 rides in as the op bit itself.
  assign b_eff = (op_i == ALU_OP_SUB) ? ~b_i : b_i;
  assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_i};
  assign res_o = sum[WIDTH-1:0];

  // Borrow is the inverted carry-out on subtract.
  assign cf_o = (op_i == ALU_OP_SUB) ? ~sum[WIDTH] : sum[WIDTH];
  assign of_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered add/subtract stage with CF/SF/ZF flags, one-cycle latency.
// Optional OF output is enabled by defining ALU_OVERFLOW_FLAG_EN.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             OP,
  output logic [WIDTH-1:0] result,
  output logic             CF,
  output logic             SF,
  output logic             ZF,
  output logic             out_valid
`ifdef ALU_OVERFLOW_FLAG_EN
  ,
  output logic             OF
`endif
);

  logic [WIDTH-1:0] raw_res;
  logic             raw_cf;
  logic             raw_of;

  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             valid_q, valid_d;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i  (A),
    .b_i  (B),
    .op_i (OP),
    .res_o(raw_res),
    .cf_o (raw_cf),
    .of_o (raw_of)
  );

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = 1'b0;
    if (in_valid) begin
      result_d   = raw_res;
      flags_d.cf = raw_cf;
      flags_d.sf = raw_res[WIDTH-1];
      flags_d.zf = (raw_res == '0);
`ifdef ALU_OVERFLOW_FLAG_EN
      flags_d.of = raw_of;
`else
      flags_d.of = 1'b0;
`endif
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= ALU_FLAGS_RST;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  assign result    = result_q;
  assign CF        = flags_q.cf;
  assign SF        = flags_q.sf;
  assign ZF        = flags_q.zf;
  assign out_valid = valid_q;

`ifdef ALU_OVERFLOW_FLAG_EN
  assign OF = flags_q.of;
`else
  logic unused_of;
  assign unused_of = raw_of ^ flags_q.of;
`endif

  // An unknown op select on an accepted cycle would corrupt result and flags.
  always @(posedge clk) begin
    if (rst_n && in_valid) begin
      assert (!$isunknown(OP)) else $error("OP is unknown while in_valid is high");
    end
  end

endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for alu against an arithmetic reference model.
module tb_alu;

  localparam int W    = 7;
  localparam int MOD  = 2 ** W;
  localparam int HALF = 2 ** (W - 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         OP = 1'b0;
  logic [W-1:0] result;
  logic         CF, SF, ZF, out_valid;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic         OF;
`endif

  int errors = 0;
  int checks = 0;

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .OP       (OP),
    .result   (result),
    .CF       (CF),
    .SF       (SF),
    .ZF       (ZF),
    .out_valid(out_valid)
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    .OF       (OF)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operands.
  logic [W-1:0] mRes = '0;
  logic         mCf = 1'b0, mSf = 1'b0, mZf = 1'b1, mOf = 1'b0, mValid = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int ua, ub, full, sa, sb, sr, r;
    if (!rst_n) begin
      mRes <= '0; mCf <= 1'b0; mSf <= 1'b0; mZf <= 1'b1; mOf <= 1'b0; mValid <= 1'b0;
    end else if (in_valid) begin
      ua   = int'(A);
      ub   = int'(B);
      full = OP ? (ua - ub) : (ua + ub);
      r    = (full + MOD) % MOD;
      sa   = (ua >= HALF) ? ua - MOD : ua;
      sb   = (ub >= HALF) ? ub - MOD : ub;
      sr   = OP ? (sa - sb) : (sa + sb);
      mRes   <= W'(r);
      mCf    <= OP ? (ua < ub) : (full >= MOD);
      mSf    <= (r >= HALF);
      mZf    <= (r == 0);
      mOf    <= (sr > HALF - 1) || (sr < -HALF);
      mValid <= 1'b1;
    end else begin
      mValid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic ofOk;
`ifdef ALU_OVERFLOW_FLAG_EN
    ofOk = (OF === mOf);
`else
    ofOk = 1'b1;
`endif
    checks++;
    if (!({result, CF, SF, ZF, out_valid} === {mRes, mCf, mSf, mZf, mValid}) || !ofOk) begin
      errors++;
      $display("[TB] FAIL cycle t=%0t: got res=%b CF=%b SF=%b ZF=%b v=%b, model res=%b CF=%b SF=%b ZF=%b v=%b OF=%b",
               $time, result, CF, SF, ZF, out_valid, mRes, mCf, mSf, mZf, mValid, mOf);
    end
  end

  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    @(negedge clk);
    in_valid = v;
    A        = a;
    B        = b;
    OP       = op;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] eRes, input logic eCf,
                             input logic eSf, input logic eZf, input logic eValid);
    checks++;
    if ({result, CF, SF, ZF, out_valid} !== {eRes, eCf, eSf, eZf, eValid}) begin
      errors++;
      $display("[TB] FAIL %s: got res=%b CF=%b SF=%b ZF=%b v=%b, want res=%b CF=%b SF=%b ZF=%b v=%b",
               name, result, CF, SF, ZF, out_valid, eRes, eCf, eSf, eZf, eValid);
    end
  endtask

  task automatic checkOf(input string name, input logic eOf);
`ifdef ALU_OVERFLOW_FLAG_EN
    checks++;
    if (OF !== eOf) begin
      errors++;
      $display("[TB] FAIL %s: got OF=%b, want OF=%b", name, OF, eOf);
    end
`else
    if (eOf === 1'bx) $display("[TB] unreachable %s", name);
`endif
  endtask

  // Sets up one accepted op and samples just after the capturing edge.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    applyStimulus(1'b1, a, b, op);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'(HALF);
      3:       return W'(HALF - 1);
      default: return W'($urandom_range(0, MOD - 1));
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_state", 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOf("reset_of", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp(7'b0000100, 7'b0000011, 1'b0);
    checkOutput("add", 7'b0000111, 1'b0, 1'b0, 1'b0, 1'b1);
    runOp(7'b0001100, 7'b0000010, 1'b1);
    checkOutput("sub", 7'b0001010, 1'b0, 1'b0, 1'b0, 1'b1);
    runOp(7'b1111111, 7'b0000001, 1'b0);
    checkOutput("add_wrap", 7'b0000000, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOf("add_wrap_of", 1'b0);
    runOp(7'b0101010, 7'b0101010, 1'b1);
    checkOutput("sub_equal", 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b1);
    runOp(7'b0000010, 7'b0000011, 1'b1);
    checkOutput("sub_borrow", 7'b1111111, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 7'b0110011, 7'b0001111, 1'b0);
      @(posedge clk);
      #2;
      checkOutput($sformatf("hold_%0d", i), 7'b1111111, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    runOp(7'b0111111, 7'b0000001, 1'b0);
    checkOutput("add_overflow", 7'b1000000, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOf("add_overflow_of", 1'b1);
    runOp(7'b1000000, 7'b0000001, 1'b1);
    checkOutput("sub_overflow", 7'b0111111, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOf("sub_overflow_of", 1'b1);

    // Mid-stream asynchronous reset, taken between clock edges.
    runOp(7'b0010101, 7'b0000111, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOf("async_reset_of", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), pickOperand(), pickOperand(), 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered two-operand add/subtract unit with carry, sign and zero flags; datapath default width 7 bits.
- Used as a small arithmetic stage inside the datapath.
- Operands are captured on a qualified input strobe; the result and flags are presented one clock later and held until the next accepted operation.

Parameters:
- WIDTH, 7, operand/result width in bits (legal range ≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and OP are valid this cycle; the operation is accepted.
- A  input  WIDTH  operand A, unsigned / two's complement.
- B  input  WIDTH  operand B.
- OP  input  1  operation select: 0 = add (A+B), 1 = subtract (A−B).
- result  output  WIDTH  registered result.
- CF  output  1  carry flag (add) / borrow flag (subtract).
- SF  output  1  sign flag.
- ZF  output  1  zero flag.
- out_valid  output  1  result/flags updated by an accepted operation on the previous cycle.
- OF  output  1  signed overflow; present only with ALU_OVERFLOW_FLAG_EN.

Behaviour:
- One clock domain; clk is used on the rising edge only. rst_n is asynchronous assert and synchronous deassert (external synchroniser); active low.
- While rst_n = 0: result = 0, CF = 0, SF = 0, out_valid = 0, OF = 0.
- ZF resets to 1, consistent with result = 0.
- Latency is exactly 1 cycle. A clock edge with in_valid = 1 registers the new result and flags and sets out_valid = 1 for that cycle.
- A clock edge with in_valid = 0 holds result and flags unchanged and clears out_valid to 0.
- Back-to-back in_valid is accepted every cycle. There is no backpressure.
- Add (OP = 0): the sum is computed on WIDTH+1 bits.
  - result = sum[WIDTH-1:0].
  - CF = sum[WIDTH] (unsigned carry out).
- Subtract (OP = 1): computed as A + ~B + 1 on WIDTH+1 bits.
  - result = low WIDTH bits.
  - CF = 1 when A < B unsigned (borrow). This is the inverted carry-out.
- SF = result[WIDTH-1].
- ZF = 1 when result == 0, else 0.
- Wrap-around is modulo 2^WIDTH with no saturation.
- A == B on subtract gives result 0, ZF = 1, CF = 0.
- If rst_n asserts mid-operation, the captured op is discarded and outputs go to reset values immediately.
- OP values other than 0/1 cannot exist. X on OP while in_valid = 1 is a verification error (assertion).

Optional Feature:
- Macro: ALU_OVERFLOW_FLAG_EN.
- When defined, the OF output port exists and is registered alongside the other flags.
  - Add: OF = 1 when A and B have the same sign and the result sign differs.
  - Subtract: OF = 1 when A and B differ in sign and the result sign differs from A's sign.
  - OF resets to 0 and holds when in_valid = 0.
- When not defined, the OF port and its logic are absent. All other behaviour is identical.

Decomposition:
- alu_pkg holds:
  - localparam ALU_OP_ADD = 1'b0 and ALU_OP_SUB = 1'b1;
  - default width constant ALU_WIDTH = 7;
  - a flags struct/typedef {cf, sf, zf, of}.
- Sub-module alu_addsub: purely combinational WIDTH-parameterised adder/subtractor.
  - Outputs: raw result, carry/borrow and overflow.
- The top level alu holds the input qualification, output/flag registers, ZF/SF derivation and the optional OF gating.

Test Plan:
- Reset: assert rst_n = 0 mid-stream -> result = 0000000, CF = 0, SF = 0, ZF = 1, out_valid = 0 asynchronously.
- Add: A = 0000100, B = 0000011, OP = 0, in_valid = 1 -> next cycle result = 0000111, CF = 0, SF = 0, ZF = 0, out_valid = 1.
- Subtract: A = 0001100, B = 0000010, OP = 1 -> result = 0001010, CF = 0, SF = 0, ZF = 0.
- Add wrap: A = 1111111, B = 0000001, OP = 0 -> result = 0000000, CF = 1, ZF = 1, SF = 0 (OF = 0 if enabled).
- Subtract borrow: A = 0000010, B = 0000011, OP = 1 -> result = 1111111, CF = 1, SF = 1, ZF = 0.
  - Follow with in_valid = 0 for 3 cycles -> outputs held, out_valid = 0.
- Overflow (ALU_OVERFLOW_FLAG_EN): A = 0111111, B = 0000001, OP = 0 -> result = 1000000, OF = 1, SF = 1, CF = 0.
